// File: rtl/hdmi_tmds_encoder.sv
// TMDS 8b/10b encoder: three DC-balanced channels (blue=0, green=1, red=2) with
// control tokens on blue during blanking. Latency is 2 + PIPE_OUT clocks.
module hdmi_tmds_encoder #(
  parameter int PIPE_OUT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       ve,
  output logic [9:0] tmds_red,
  output logic [9:0] tmds_green,
  output logic [9:0] tmds_blue
);

  localparam logic [9:0] TOKEN_00 = 10'h354;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'h354;
      2'b01:   t = 10'h0AB;
      2'b10:   t = 10'h154;
      2'b11:   t = 10'h2AB;
      default: t = 10'h354;
    endcase
    return t;
  endfunction

  logic [2:0][7:0] din_s;
  logic [2:0][9:0] q2_s;
  logic            s1_ve_r;
  logic [1:0]      s1_c_r;

  assign din_s = {red, green, blue};

  // Stage-1 copy of video enable and {vsync,hsync}, shared by all channels
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_ve_r <= 1'b0;
      s1_c_r  <= 2'b00;
    end else begin
      s1_ve_r <= ve;
      s1_c_r  <= {vsync, hsync};
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    localparam bit IS_BLUE = (ch == 0);

    logic [7:0]        d_r;
    logic [3:0]        n1d_r;
    logic [8:0]        qm_s;
    logic signed [5:0] bal_s;
    logic signed [5:0] cnt_r;
    logic signed [5:0] cnt_nxt_s;
    logic [9:0]        q_r;
    logic [9:0]        q_nxt_s;

    // Stage 1: pixel byte and its ones count
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        d_r   <= 8'h00;
        n1d_r <= 4'd0;
      end else begin
        d_r   <= din_s[ch];
        n1d_r <= popcount8(din_s[ch]);
      end
    end

    // Transition-minimised word; bal_s is ones minus zeros of its low byte
    always_comb begin : b_qm
      logic [8:0] m;
      m    = 9'd0;
      m[0] = d_r[0];
      if (n1d_r > 4'd4 || (n1d_r == 4'd4 && !d_r[0])) begin
        for (int i = 1; i < 8; i++) begin
          m[i] = ~(m[i-1] ^ d_r[i]);
        end
        m[8] = 1'b0;
      end else begin
        for (int i = 1; i < 8; i++) begin
          m[i] = m[i-1] ^ d_r[i];
        end
        m[8] = 1'b1;
      end
      qm_s  = m;
      bal_s = $signed({1'b0, popcount8(m[7:0]), 1'b0}) - 6'sd8;
    end

    // DC-balance decision and running disparity update
    always_comb begin
      q_nxt_s   = TOKEN_00;
      cnt_nxt_s = cnt_r;
      if (!s1_ve_r) begin
        cnt_nxt_s = 6'sd0;
        if (IS_BLUE) begin
          q_nxt_s = ctrl_token(s1_c_r);
        end else begin
          q_nxt_s = TOKEN_00;
        end
      end else if (cnt_r == 6'sd0 || bal_s == 6'sd0) begin
        q_nxt_s = {~qm_s[8], qm_s[8], qm_s[8] ? qm_s[7:0] : ~qm_s[7:0]};
        if (qm_s[8]) begin
          cnt_nxt_s = cnt_r + bal_s;
        end else begin
          cnt_nxt_s = cnt_r - bal_s;
        end
      end else if ((cnt_r > 6'sd0 && bal_s > 6'sd0) || (cnt_r < 6'sd0 && bal_s < 6'sd0)) begin
        q_nxt_s   = {1'b1, qm_s[8], ~qm_s[7:0]};
        cnt_nxt_s = cnt_r - bal_s + (qm_s[8] ? 6'sd2 : 6'sd0);
      end else begin
        q_nxt_s   = {1'b0, qm_s[8], qm_s[7:0]};
        cnt_nxt_s = cnt_r + bal_s - (qm_s[8] ? 6'sd0 : 6'sd2);
      end
    end

    // Stage 2: encoded character and disparity counter
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        q_r   <= TOKEN_00;
        cnt_r <= 6'sd0;
      end else begin
        q_r   <= q_nxt_s;
        cnt_r <= cnt_nxt_s;
      end
    end

    assign q2_s[ch] = q_r;
  end

  if (PIPE_OUT != 0) begin : g_pipe
    logic [2:0][9:0] out_r;

    // Optional retiming register toward the serializer
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        out_r <= {3{TOKEN_00}};
      end else begin
        out_r <= q2_s;
      end
    end

    assign {tmds_red, tmds_green, tmds_blue} = out_r;
  end else begin : g_nopipe
    assign {tmds_red, tmds_green, tmds_blue} = q2_s;
  end

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Bench for hdmi_tmds_encoder: PIPE_OUT=1 and PIPE_OUT=0 instances checked each
// cycle against a disparity-tracking reference model, plus literal spot checks.
module tb_hdmi_tmds_encoder;

  localparam int NC = 16384;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] red = 8'h00, green = 8'h00, blue = 8'h00;
  logic       hsync = 1'b0, vsync = 1'b0, ve = 1'b0;
  logic [9:0] r3, g3, b3, r2, g2, b2;

  hdmi_tmds_encoder #(.PIPE_OUT(1)) u3 (
    .clock(clock), .reset(reset), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .ve(ve),
    .tmds_red(r3), .tmds_green(g3), .tmds_blue(b3)
  );

  hdmi_tmds_encoder #(.PIPE_OUT(0)) u2 (
    .clock(clock), .reset(reset), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .ve(ve),
    .tmds_red(r2), .tmds_green(g2), .tmds_blue(b2)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 4;
  logic [9:0] hr [NC];
  logic [9:0] hg [NC];
  logic [9:0] hb [NC];
  logic       hw [NC];
  int mcnt [4];
  int sum [3];
  logic in_line = 1'b0;

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: pick the inversion that pulls the running disparity toward zero,
  // then track disparity as the real ones-minus-zeros of each emitted character.
  function automatic logic [9:0] enc(input logic [7:0] d, input logic de,
                                     input logic [1:0] c, input int ch);
    logic [8:0] q;
    logic [9:0] w;
    logic       use_xnor;
    logic       inv;
    int         n1;
    if (!de) begin
      mcnt[ch] = 0;
      case (c)
        2'b00:   return 10'h354;
        2'b01:   return 10'h0AB;
        2'b10:   return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && !d[0]);
    q = 9'd0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !use_xnor;
    n1 = $countones(q[7:0]);
    if (mcnt[ch] == 0 || n1 == 4) inv = ~q[8];
    else inv = ((mcnt[ch] > 0) == (n1 > 4));
    w = {inv, q[8], inv ? ~q[7:0] : q[7:0]};
    mcnt[ch] += 2 * $countones(w) - 10;
    return w;
  endfunction

  task automatic step(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic hs, input logic vs, input logic de,
                      input logic wht, input logic rel);
    @(posedge clock);
    cyc++;
    #1;
    if (rel) reset = 1'b1;
    red = r; green = g; blue = b; hsync = hs; vsync = vs; ve = de;
    if (!reset) begin
      hr[cyc] = 10'h354; hg[cyc] = 10'h354; hb[cyc] = 10'h354;
      for (int i = 0; i < 3; i++) mcnt[i] = 0;
    end else begin
      hb[cyc] = enc(b, de, {vs, hs}, 0);
      hg[cyc] = enc(g, de, 2'b00, 1);
      hr[cyc] = enc(r, de, 2'b00, 2);
    end
    hw[cyc] = wht & reset & de;
  endtask

  task automatic assert_rst();
    #2;
    reset = 1'b0;
    #1;
    chk("async rst r3", r3, 10'h354); chk("async rst g3", g3, 10'h354);
    chk("async rst b3", b3, 10'h354); chk("async rst r2", r2, 10'h354);
    chk("async rst g2", g2, 10'h354); chk("async rst b2", b2, 10'h354);
    for (int i = 0; i < 4; i++) begin
      hr[cyc-i] = 10'h354; hg[cyc-i] = 10'h354; hb[cyc-i] = 10'h354; hw[cyc-i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
  endtask

  // Per-cycle comparison of both instances, plus per-line balance on white lines
  always @(negedge clock) begin
    chk("u3 red", r3, hr[cyc-3]);   chk("u3 green", g3, hg[cyc-3]); chk("u3 blue", b3, hb[cyc-3]);
    chk("u2 red", r2, hr[cyc-2]);   chk("u2 green", g2, hg[cyc-2]); chk("u2 blue", b2, hb[cyc-2]);
    if (hw[cyc-3]) begin
      sum[0] += 2 * $countones(b3) - 10;
      sum[1] += 2 * $countones(g3) - 10;
      sum[2] += 2 * $countones(r3) - 10;
      in_line = 1'b1;
    end else if (in_line) begin
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (sum[c] > 10 || sum[c] < -10) begin
          errors++;
          $display("FAIL line balance ch%0d: got %0d required within +-10", c, sum[c]);
        end
        sum[c] = 0;
      end
      in_line = 1'b0;
    end
  end

  logic [9:0] tok_exp [4];
  logic [9:0] v;
  logic       de_r;

  initial begin
    for (int i = 0; i < NC; i++) begin
      hr[i] = 10'h354; hg[i] = 10'h354; hb[i] = 10'h354; hw[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    for (int i = 0; i < 3; i++) sum[i] = 0;
    tok_exp[0] = 10'h354; tok_exp[1] = 10'h0AB; tok_exp[2] = 10'h154; tok_exp[3] = 10'h2AB;

    // Pin the model with hand-computed characters and disparities
    mcnt[3] = 0;
    v = enc(8'h00, 1'b1, 2'b00, 3); chk("pin blk1", v, 10'h100); chk("pin cnt1", 10'(mcnt[3]), 10'h3F8);
    v = enc(8'h00, 1'b1, 2'b00, 3); chk("pin blk2", v, 10'h3FF); chk("pin cnt2", 10'(mcnt[3]), 10'h002);
    v = enc(8'h00, 1'b1, 2'b00, 3); chk("pin blk3", v, 10'h100); chk("pin cnt3", 10'(mcnt[3]), 10'h3FA);
    mcnt[3] = 0;
    v = enc(8'hFF, 1'b1, 2'b00, 3); chk("pin white", v, 10'h200);
    v = enc(8'h5A, 1'b0, 2'b01, 3); chk("pin tok01", v, 10'h0AB);

    // Reset held low, then released into a quiet control period
    for (int i = 0; i < 4; i++) step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset r3", r3, 10'h354); chk("reset b2", b2, 10'h354);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle b3", b3, 10'h354); chk("idle g2", g2, 10'h354);

    // Control tokens stepped 00,01,10,11
    for (int i = 0; i < 7; i++) begin
      step(8'h00, 8'h00, 8'h00, (i < 4) ? i[0] : 1'b1, (i < 4) ? i[1] : 1'b1, 1'b0, 1'b0, 1'b0);
      if (i >= 3) begin
        chk("token b3", b3, tok_exp[i-3]);
        chk("token r3", r3, 10'h354);
      end
    end

    // DC balance: three black pixels from cnt=0
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("dc b2 #1", b2, 10'h100);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dc b3 #1", b3, 10'h100); chk("dc b2 #2", b2, 10'h3FF);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dc b3 #2", b3, 10'h3FF); chk("dc r2 #3", r2, 10'h100);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dc b3 #3", b3, 10'h100); chk("dc g3 #3", g3, 10'h100);

    // Latency: single red=FF pixel surrounded by blanking
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lat r3 +0", r3, 10'h354);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat r3 +1", r3, 10'h354);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat r3 +2", r3, 10'h354); chk("lat r2 +2", r2, 10'h200);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat r3 +3", r3, 10'h200); chk("lat g3 +3", g3, 10'h100); chk("lat b3 +3", b3, 10'h100);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat r3 +4", r3, 10'h354);

    // Randomized traffic with occasional mid-frame resets
    de_r = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 11) == 0) de_r = ~de_r;
      step(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), de_r, 1'b0, 1'b0);
      if ($urandom_range(0, 399) == 0 && de_r) begin
        assert_rst();
        step(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
    end

    // Forced mid-frame reset during active video
    for (int i = 0; i < 6; i++) step(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    assert_rst();
    step(8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h9A, 8'hBC, 8'hDE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Two 1280-pixel white lines with blanking between
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < 40; i++) step(8'h00, 8'h00, 8'h00, 1'b0, 1'(ln), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 1280; i++) step(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 8; i++) step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
